// File: rtl/fp_div_pipe_driver.sv
// Issue/collect controller for the pipelined FP divider: credit-limited launch plus show-ahead
// result FIFO. Define FP_DIV_DRV_IDCHK_EN to add arrival ID sequence checking (err[1]).
module fp_div_pipe_driver #(
    parameter int unsigned sig_width  = 10,
    parameter int unsigned exp_width  = 5,
    parameter int unsigned id_width   = 8,
    parameter int unsigned fifo_depth = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [sig_width+exp_width:0]   in_a,
    input  logic [sig_width+exp_width:0]   in_b,
    input  logic [2:0]                     in_rnd,
    output logic                           launch,
    output logic [id_width-1:0]            launch_id,
    output logic [sig_width+exp_width:0]   a_out,
    output logic [sig_width+exp_width:0]   b_out,
    output logic [2:0]                     rnd_out,
    input  logic                           pipe_full,
    input  logic                           pipe_ovf,
    output logic                           accept_n,
    input  logic                           arrive,
    input  logic [id_width-1:0]            arrive_id,
    input  logic                           push_out_n,
    input  logic [sig_width+exp_width:0]   z_in,
    input  logic [7:0]                     status_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [sig_width+exp_width:0]   out_z,
    output logic [7:0]                     out_status,
    output logic [id_width-1:0]            out_id,
    output logic [$clog2(fifo_depth+1)-1:0] tokens,
    output logic [1:0]                     err
);

    localparam int unsigned W  = sig_width + exp_width + 1;
    localparam int unsigned TW = $clog2(fifo_depth + 1);
    localparam int unsigned AW = $clog2(fifo_depth);
    localparam int unsigned EW = W + 8 + id_width;

    typedef logic [EW-1:0] entry_t;

    logic [TW-1:0]       tokens_q, tokens_d;
    logic [id_width-1:0] next_id_q;
    logic                launch_q;
    logic [id_width-1:0] launch_id_q;
    logic [W-1:0]        a_q, b_q;
    logic [2:0]          rnd_q;
    logic [AW:0]         wr_ptr_q, rd_ptr_q;
    entry_t              mem_q [fifo_depth];
    entry_t              head;
    logic [1:0]          err_q, err_d;
    logic                in_hs, pop, full, empty, wr_en, drop, id_mis;

    // Monitor-only input; kept visible so it is not flagged as dangling.
    logic unused_push_out_n;
    assign unused_push_out_n = push_out_n;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign in_ready = (tokens_q < TW'(fifo_depth)) & ~pipe_full;
    assign in_hs = in_valid & in_ready;
    assign pop   = ~empty & out_ready;
    assign wr_en = arrive & ~full;
    assign drop  = arrive & full;

    always_comb begin
        tokens_d = tokens_q;
        unique case ({in_hs, pop})
            2'b10:   tokens_d = tokens_q + TW'(1);
            2'b01:   tokens_d = tokens_q - TW'(1);
            default: tokens_d = tokens_q;
        endcase
    end

`ifdef FP_DIV_DRV_IDCHK_EN
    logic [id_width-1:0] expect_id_q;

    assign id_mis = wr_en & (arrive_id != expect_id_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expect_id_q <= '0;
        end else if (wr_en) begin
            expect_id_q <= expect_id_q + id_width'(1);
        end
    end
`else
    assign id_mis = 1'b0;
`endif

    always_comb begin
        err_d = err_q | {id_mis, pipe_ovf | drop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tokens_q    <= '0;
            next_id_q   <= '0;
            launch_q    <= 1'b0;
            launch_id_q <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rnd_q       <= '0;
            err_q       <= '0;
        end else begin
            tokens_q <= tokens_d;
            err_q    <= err_d;
            launch_q <= in_hs;
            if (in_hs) begin
                launch_id_q <= next_id_q;
                next_id_q   <= next_id_q + id_width'(1);
                a_q         <= in_a;
                b_q         <= in_b;
                rnd_q       <= in_rnd;
            end
        end
    end

    // Storage is cleared on reset so the head reads as zero when nothing is buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < fifo_depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {z_in, status_in, arrive_id};
                wr_ptr_q                <= wr_ptr_q + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid  = ~empty;
    assign out_z      = head[EW-1 -: W];
    assign out_status = head[id_width +: 8];
    assign out_id     = head[id_width-1:0];
    assign accept_n   = full;

    assign launch    = launch_q;
    assign launch_id = launch_id_q;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign rnd_out   = rnd_q;
    assign tokens    = tokens_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fp_div_pipe_driver.sv
// Directed bench for fp_div_pipe_driver with a fixed-latency divider model.
module tb_fp_div_pipe_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] in_a = '0, in_b = '0;
    logic [2:0]  in_rnd = '0;
    logic        launch;
    logic [7:0]  launch_id;
    logic [15:0] a_out, b_out;
    logic [2:0]  rnd_out;
    logic        pipe_full = 1'b0, pipe_ovf = 1'b0, accept_n;
    logic        arrive = 1'b0;
    logic [7:0]  arrive_id = '0;
    logic        push_out_n = 1'b1;
    logic [15:0] z_in = '0;
    logic [7:0]  status_in = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [15:0] out_z;
    logic [7:0]  out_status, out_id;
    logic [2:0]  tokens;
    logic [1:0]  err;

    int n_vec = 0;
    int n_bad = 0;
    logic bad_en = 1'b0;

`ifdef FP_DIV_DRV_IDCHK_EN
    localparam logic IdChk = 1'b1;
`else
    localparam logic IdChk = 1'b0;
`endif

    fp_div_pipe_driver dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_rnd(in_rnd), .launch(launch), .launch_id(launch_id),
        .a_out(a_out), .b_out(b_out), .rnd_out(rnd_out), .pipe_full(pipe_full),
        .pipe_ovf(pipe_ovf), .accept_n(accept_n), .arrive(arrive), .arrive_id(arrive_id),
        .push_out_n(push_out_n), .z_in(z_in), .status_in(status_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_z(out_z), .out_status(out_status), .out_id(out_id),
        .tokens(tokens), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] op_a(input int k);
        return {8'h10, k[7:0]};
    endfunction

    function automatic logic [15:0] op_b(input int k);
        return {8'h21, k[6:0], k[7]};
    endfunction

    function automatic logic [15:0] div_model(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h3C00 && b == 16'h4000) return 16'h3800;
        return a ^ b;
    endfunction

    function automatic logic [7:0] stat_model(input logic [15:0] a, input logic [15:0] b);
        return a[7:0] ^ b[15:8];
    endfunction

    // Divider model: result arrives a fixed number of cycles after launch.
    logic [3:0]  st_v = '0;
    logic [7:0]  st_id [4];
    logic [15:0] st_z [4];
    logic [7:0]  st_s [4];

    always @(negedge clk) begin
        if (!rst_n) begin
            st_v = '0;
        end else begin
            for (int i = 3; i > 0; i--) begin
                st_v[i] = st_v[i-1];
                st_id[i] = st_id[i-1];
                st_z[i] = st_z[i-1];
                st_s[i] = st_s[i-1];
            end
            st_v[0] = launch;
            st_id[0] = (bad_en && launch_id == 8'd3) ? 8'd5 : launch_id;
            st_z[0] = div_model(a_out, b_out);
            st_s[0] = stat_model(a_out, b_out);
        end
        arrive = st_v[3];
        arrive_id = st_id[3];
        z_in = st_z[3];
        status_in = st_s[3];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k);
        in_valid = 1'b1;
        in_a = op_a(k);
        in_b = op_b(k);
        in_rnd = k[2:0];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        pipe_ovf = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_tokens", tokens, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_launch", launch, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_accept_n", accept_n, 0);
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_out(input int bound);
        int c = 0;
        while (!out_valid && c < bound) begin
            step();
            c++;
        end
        if (!out_valid) check_eq("out_timeout", 0, 1);
    endtask

    initial begin
        int hs, issued, exp_lid, exp_oid, cyc, n, c;
        logic hs_now;

        // Single op: 1.0 / 2.0
        do_reset();
        in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h4000; in_rnd = 3'd0;
        check_eq("t1_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check_eq("t1_launch", launch, 1);
        check_eq("t1_launch_id", launch_id, 0);
        check_eq("t1_a_out", a_out, 16'h3C00);
        check_eq("t1_b_out", b_out, 16'h4000);
        check_eq("t1_rnd_out", rnd_out, 0);
        check_eq("t1_tokens", tokens, 1);
        step();
        check_eq("t1_launch_low", launch, 0);
        check_eq("t1_a_hold", a_out, 16'h3C00);
        wait_out(20);
        check_eq("t1_out_z", out_z, 16'h3800);
        check_eq("t1_out_status", out_status, 8'h40);
        check_eq("t1_out_id", out_id, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("t1_tokens_end", tokens, 0);
        check_eq("t1_out_valid_end", out_valid, 0);

        // Fill with out_ready low, then drain with one simultaneous issue+pop
        do_reset();
        hs = 0;
        for (int i = 0; i < 6; i++) begin
            issue(hs);
            if (in_ready) hs++;
            step();
        end
        in_valid = 1'b0;
        check_eq("t2_handshakes", hs, 4);
        check_eq("t2_tokens", tokens, 4);
        check_eq("t2_in_ready", in_ready, 0);
        repeat (8) step();
        check_eq("t2_out_valid", out_valid, 1);
        check_eq("t2_accept_n", accept_n, 1);
        check_eq("t2_id0", out_id, 0);
        check_eq("t2_z0", out_z, div_model(op_a(0), op_b(0)));
        out_ready = 1'b1;
        step();
        check_eq("t2_tokens_pop", tokens, 3);
        check_eq("t2_in_ready_back", in_ready, 1);
        check_eq("t2_id1", out_id, 1);
        issue(4);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check_eq("t3_tokens_same", tokens, 3);
        check_eq("t3_id2", out_id, 2);
        check_eq("t3_launch", launch, 1);
        check_eq("t3_launch_id", launch_id, 4);
        check_eq("t3_err", err, 0);
        out_ready = 1'b1;
        step();
        check_eq("t3_id3", out_id, 3);
        check_eq("t3_z3", out_z, div_model(op_a(3), op_b(3)));
        step();
        out_ready = 1'b0;
        check_eq("t3_tokens_1", tokens, 1);
        wait_out(20);
        check_eq("t3_id4", out_id, 4);
        check_eq("t3_z4", out_z, div_model(op_a(4), op_b(4)));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("t3_tokens_end", tokens, 0);
        check_eq("t3_err_end", err, 0);

        // Stream 260 ops across the ID wrap
        do_reset();
        issued = 0; exp_lid = 0; exp_oid = 0; cyc = 0;
        out_ready = 1'b1;
        while (exp_oid < 260 && cyc < 6000) begin
            if (issued < 260) issue(issued);
            else in_valid = 1'b0;
            hs_now = in_valid && in_ready;
            if (out_valid) begin
                check_eq("t4_out_id", out_id, exp_oid % 256);
                check_eq("t4_out_z", out_z, div_model(op_a(exp_oid), op_b(exp_oid)));
                exp_oid++;
            end
            step();
            cyc++;
            if (hs_now) issued++;
            if (launch) begin
                check_eq("t4_launch_id", launch_id, exp_lid % 256);
                exp_lid++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check_eq("t4_results", exp_oid, 260);
        check_eq("t4_launches", exp_lid, 260);
        check_eq("t4_tokens", tokens, 0);
        check_eq("t4_err", err, 0);

        // Error injection: bad arrival ID, then pipe_ovf pulse
        do_reset();
        bad_en = 1'b1;
        out_ready = 1'b1;
        n = 0; c = 0;
        while (n < 4 && c < 40) begin
            issue(n);
            if (in_ready) n++;
            step();
            c++;
        end
        in_valid = 1'b0;
        c = 0;
        while (tokens != 0 && c < 40) begin
            step();
            c++;
        end
        bad_en = 1'b0;
        out_ready = 1'b0;
        check_eq("t5_tokens", tokens, 0);
        check_eq("t5_err_id", err, {30'd0, IdChk, 1'b0});
        pipe_ovf = 1'b1;
        step();
        pipe_ovf = 1'b0;
        check_eq("t5_err_ovf", err, {30'd0, IdChk, 1'b1});
        repeat (3) step();
        check_eq("t5_err_sticky", err, {30'd0, IdChk, 1'b1});

        // Reset with 3 in flight and 1 buffered
        do_reset();
        n = 0; c = 0;
        while (n < 4 && c < 20) begin
            issue(n + 16);
            if (in_ready) n++;
            step();
            c++;
        end
        in_valid = 1'b0;
        wait_out(20);
        check_eq("t6_tokens_pre", tokens, 4);
        rst_n = 1'b0;
        #1;
        check_eq("t6_launch", launch, 0);
        check_eq("t6_a_out", a_out, 0);
        check_eq("t6_out_valid", out_valid, 0);
        check_eq("t6_out_z", out_z, 0);
        check_eq("t6_out_id", out_id, 0);
        check_eq("t6_tokens", tokens, 0);
        check_eq("t6_accept_n", accept_n, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        issue(7);
        step();
        in_valid = 1'b0;
        check_eq("t6_first_launch_id", launch_id, 0);
        check_eq("t6_first_launch", launch, 1);
        wait_out(20);
        check_eq("t6_out_id_new", out_id, 0);
        check_eq("t6_out_z_new", out_z, div_model(op_a(7), op_b(7)));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (6) step();
        check_eq("t6_tokens_end", tokens, 0);
        check_eq("t6_no_stale", out_valid, 0);
        check_eq("t6_err_end", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
